config_loader: RTL
==================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001: The block SHALL have parameter CONFIG_WIDTH, default 8, width of one configuration word and of the stream bus.
REQ-002: The block SHALL have parameter CHAIN_WORDS, default 4, number of words in the downstream configuration chain (4 = one S44 cell of two 4-input LUTs); legal range 1..1024.
REQ-003: Port config_clk, input, 1, the single clock; the downstream chain also shifts on its rising edge.
REQ-004: Port config_rst, input, 1, reset, asynchronous, active-high.
REQ-005: Port start, input, 1, one-cycle request to begin a load.
REQ-006: Port abort, input, 1, cancels a load in progress.
REQ-007: Port in_valid, input, 1, source word valid.
REQ-008: Port in_data, input, CONFIG_WIDTH, source word.
REQ-009: Port in_ready, output, 1, block accepts in_data this cycle.
REQ-010: Port config_en, output, 1, chain shift enable.
REQ-011: Port config_in, output, CONFIG_WIDTH, word driven into the head of the chain.
REQ-012: Port chain_out, input, CONFIG_WIDTH, config_out of the last element of the chain.
REQ-013: Port rb_valid, output, 1, readback word valid.
REQ-014: Port rb_data, output, CONFIG_WIDTH, word shifted out of the chain tail.
REQ-015: Port busy, output, 1, high in any state other than IDLE.
REQ-016: Port done, output, 1, one-cycle pulse on successful load completion.
REQ-017: Port error, output, 1, sticky flag, set by abort.

Function
REQ-018: The block SHALL implement states IDLE, LOAD, DRAIN and DONE.
REQ-019: IDLE -> LOAD on start=1; start SHALL be ignored in every other state.
REQ-020: Entering LOAD SHALL clear the word counter to 0 and clear error.
REQ-021: in_ready SHALL equal (state==LOAD) && (count<CHAIN_WORDS) && !abort, combinationally.
REQ-022: An accept (in_valid && in_ready) SHALL increment the counter; the counter width is clog2(CHAIN_WORDS+1) and it never wraps.
REQ-023: config_en and config_in SHALL be registered: the cycle after an accept, config_en=1 and config_in=the accepted word; otherwise config_en=0 and config_in holds its last value.
REQ-024: LOAD -> DRAIN in the cycle the CHAIN_WORDS-th word is accepted; DRAIN lasts exactly one cycle, during which the final config_en=1 is issued.
REQ-025: DRAIN -> DONE; DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-026: in_valid gaps in LOAD SHALL stall without timeout; no chain shift occurs on a non-accept cycle.
REQ-027: Readback: in every cycle with config_en=1, chain_out SHALL be captured, and the next cycle SHALL present rb_valid=1 and rb_data=the captured word; rb has no backpressure.
REQ-028: abort=1 in LOAD SHALL move to IDLE next cycle, set error=1, and suppress the same-cycle accept (no config_en follows it); words already accepted still complete their shift.
REQ-029: abort in IDLE, DRAIN or DONE SHALL be ignored and SHALL NOT set error.
REQ-030: abort and the final-word accept in the same cycle: abort wins (final word not accepted, error=1, no done).
REQ-031: For a completed load, exactly CHAIN_WORDS config_en pulses SHALL occur and exactly CHAIN_WORDS rb_valid pulses SHALL follow, in order.

Reset
REQ-032: config_rst=1 SHALL asynchronously force state=IDLE, count=0, in_ready=0, config_en=0, config_in=0, rb_valid=0, rb_data=0, busy=0, done=0, error=0.
REQ-033: Reset mid-LOAD SHALL abandon the load without any further config_en pulse; release returns to IDLE and awaits start.

Verification
REQ-034: Defaults, start, words 0x11,0x22,0x33,0x44 back-to-back -> config_en high 4 consecutive cycles with config_in 0x11..0x44, done pulses 2 cycles after the 0x44 accept, busy drops with done.
REQ-035: Same load with in_valid low 3 cycles between every word -> same config_in sequence, no extra config_en, done exactly once.
REQ-036: Chain model preloaded 0xA0,0xA1,0xA2,0xA3 (tail first) -> rb_data yields 0xA0,0xA1,0xA2,0xA3, each one cycle after the matching config_en.
REQ-037: Abort after 2 accepts -> 2 config_en pulses only, error=1, no done; next start clears error and a full load succeeds.
REQ-038: Abort coincident with the 4th word -> 3 config_en pulses, error=1, done never asserted; start during LOAD and DONE -> ignored.
REQ-039: config_rst asserted after 1 accept, mid-cycle -> all outputs 0 immediately, no further config_en after release.

Source files
------------

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Streams CHAIN_WORDS configuration words from a valid/ready source into a
// shift-register configuration chain, then reads the displaced chain contents
// back out. Each accepted word is shifted into the chain head one cycle after
// its acceptance. The word leaving the chain tail on every shift is captured
// and presented one cycle later on the readback port.
//
// Parameters
//   CONFIG_WIDTH : width of one configuration word and of the stream bus
//   CHAIN_WORDS  : number of words in the downstream chain (1..1024)
//
// Ports
//   config_clk  in   single clock; the downstream chain shifts on its rising edge
//   config_rst  in   asynchronous active-high reset
//   start       in   one-cycle request to begin a load (honoured in IDLE only)
//   abort       in   cancels a load in progress (honoured in LOAD only)
//   in_valid    in   source word valid
//   in_data     in   source word
//   in_ready    out  block accepts in_data this cycle (combinational)
//   config_en   out  chain shift enable (registered)
//   config_in   out  word driven into the chain head (registered)
//   chain_out   in   word presented by the last element of the chain
//   rb_valid    out  readback word valid (registered)
//   rb_data     out  word shifted out of the chain tail (registered)
//   busy        out  high in any state other than IDLE
//   done        out  one-cycle pulse on successful load completion
//   error       out  sticky flag set by an abort, cleared by the next start
// -----------------------------------------------------------------------------
module config_loader #(
  parameter int CONFIG_WIDTH = 8,
  parameter int CHAIN_WORDS  = 4
) (
  input  logic                    config_clk,
  input  logic                    config_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [CONFIG_WIDTH-1:0] in_data,
  output logic                    in_ready,
  output logic                    config_en,
  output logic [CONFIG_WIDTH-1:0] config_in,
  input  logic [CONFIG_WIDTH-1:0] chain_out,
  output logic                    rb_valid,
  output logic [CONFIG_WIDTH-1:0] rb_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  // Counter is wide enough to hold CHAIN_WORDS itself, so it never wraps.
  localparam int CW = $clog2(CHAIN_WORDS + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(CHAIN_WORDS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CHAIN_WORDS - 1);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_COUNT = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [CW-1:0]           count_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic                    config_en_r;
  logic [CONFIG_WIDTH-1:0] config_in_r;
  logic                    rb_valid_r;
  logic [CONFIG_WIDTH-1:0] rb_data_r;
  logic                    in_ready_s;
  logic                    accept_s;

  // Handshake: ready only while loading with room left; abort masks the
  // same-cycle accept so an aborted word never reaches the chain.
  always_comb begin
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    if ((state_r == ST_LOAD) && (count_r < FULL_COUNT) && !abort) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = in_valid && in_ready_s;
  end

  // Control FSM: state, word counter and the busy/done/error status flags.
  always_ff @(posedge config_clk or posedge config_rst) begin
    if (config_rst) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_COUNT;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_LOAD;
            count_r <= ZERO_COUNT;
            busy_r  <= 1'b1;
            error_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
          end else if (accept_s) begin
            count_r <= count_r + ONE_COUNT;
            // The final word's shift is issued during DRAIN.
            if (count_r == LAST_COUNT) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_LOAD;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= ZERO_COUNT;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Chain drive: one shift per accepted word, issued the cycle after the accept.
  always_ff @(posedge config_clk or posedge config_rst) begin
    if (config_rst) begin
      config_en_r <= 1'b0;
      config_in_r <= {CONFIG_WIDTH{1'b0}};
    end else begin
      config_en_r <= accept_s;
      if (accept_s) begin
        config_in_r <= in_data;
      end else begin
        config_in_r <= config_in_r;
      end
    end
  end

  // Readback: the tail word displaced by each shift appears one cycle later.
  always_ff @(posedge config_clk or posedge config_rst) begin
    if (config_rst) begin
      rb_valid_r <= 1'b0;
      rb_data_r  <= {CONFIG_WIDTH{1'b0}};
    end else begin
      rb_valid_r <= config_en_r;
      if (config_en_r) begin
        rb_data_r <= chain_out;
      end else begin
        rb_data_r <= rb_data_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign config_en = config_en_r;
  assign config_in = config_in_r;
  assign rb_valid  = rb_valid_r;
  assign rb_data   = rb_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule
